rle_decoder: RTL and testbench

- Run-length decoder: the receive-side counterpart of the team's RLE bit-stream encoder.
- Accepts (bit value, run length, last) tokens over a valid/ready handshake and expands each token into a serial bit stream, one bit per accepted output beat.
- Sits between the token FIFO/link and the bit-serial consumer.
- Zero-bubble between consecutive tokens: the next token is accepted in the same cycle the previous run's final bit is taken.

---
 rtl/rle_pkg.sv | 12 +
 rtl/rle_run_counter.sv | 30 +++
 rtl/rle_decoder.sv | 97 +++++++++
 tb/tb_rle_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the RLE encoder/decoder pair: default run-length
// width and the decoder state encoding.
package rle_pkg;

    localparam int unsigned RLE_CNT_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

endpackage

// File: rtl/rle_run_counter.sv
// Loadable down-counter tracking the bits still to emit in the current run.
// Load has priority over decrement.
module rle_run_counter
    import rle_pkg::*;
#(
    parameter int unsigned CNT_W = RLE_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - CNT_W'(1);
        end
    end

    assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (bit, length, last) tokens into a serial bit
// stream, accepting the next token on the final beat of the current run.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int unsigned CNT_W = RLE_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [CNT_W-1:0] in_len,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             err_zero_len
);

    state_t state, next_state;
    logic   bit_q, last_q;
    logic   load, dec, is_one, err_d, ready_int, len_nz;

    assign len_nz = (in_len != '0);

    rle_run_counter #(.CNT_W(CNT_W)) u_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_val (in_len),
        .dec      (dec),
        .is_one   (is_one)
    );

    always_comb begin
        next_state = state;
        load       = 1'b0;
        dec        = 1'b0;
        err_d      = 1'b0;
        ready_int  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_int = 1'b1;
                if (in_valid) begin
                    if (len_nz) begin
                        load       = 1'b1;
                        next_state = ST_EXPAND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                if (out_ready) begin
                    if (is_one) begin
                        // Final beat: take the next token now so runs stay contiguous
                        ready_int = 1'b1;
                        if (in_valid && len_nz) begin
                            load = 1'b1;
                        end else begin
                            err_d      = in_valid;
                            next_state = ST_IDLE;
                        end
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_q        <= 1'b0;
            last_q       <= 1'b0;
            err_zero_len <= 1'b0;
        end else begin
            state        <= next_state;
            err_zero_len <= err_d;
            if (load) begin
                bit_q  <= in_bit;
                last_q <= in_last;
            end
        end
    end

    // Ready is held low while reset is asserted, even though the FSM sits in IDLE
    assign in_ready  = reset && ready_int;
    assign out_valid = (state == ST_EXPAND);
    assign out_bit   = bit_q;
    assign out_last  = out_valid && last_q && is_one;

endmodule

// File: tb/tb_rle_decoder.sv
// Directed bench for rle_decoder: each cycle inputs change 1ns after the
// rising edge and outputs are checked 1ns later.
module tb_rle_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_bit, in_last;
    logic [7:0] in_len;
    logic       out_valid, out_ready, out_bit, out_last, err_zero_len;

    int errors = 0;
    int checks = 0;
    int beats;
    int rdy [8] = '{1, 0, 0, 1, 1, 0, 1, 1};

    always #5 clock = ~clock;

    rle_decoder #(.CNT_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bit       (in_bit),
        .in_len       (in_len),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bit      (out_bit),
        .out_last     (out_last),
        .err_zero_len (err_zero_len)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic token(input logic v, input logic b, input logic [7:0] len, input logic l);
        in_valid = v;
        in_bit   = b;
        in_len   = len;
        in_last  = l;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic b, input logic l,
                              input logic rdy_exp);
        #1;
        check({tag, ".out_valid"}, out_valid, v);
        if (v) check({tag, ".out_bit"}, out_bit, b);
        check({tag, ".out_last"}, out_last, l);
        check({tag, ".in_ready"}, in_ready, rdy_exp);
    endtask

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        token(1'b0, 1'b0, 8'd0, 1'b0);
        #2;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_bit", out_bit, 1'b0);
        check("rst.out_last", out_last, 1'b0);
        check("rst.err", err_zero_len, 1'b0);
        check("rst.in_ready", in_ready, 1'b0);
        tick();
        reset = 1'b1;

        // (1,3,0): three 1-bits starting the cycle after acceptance
        token(1'b1, 1'b1, 8'd3, 1'b0);
        expect_out("t1.idle", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        token(1'b0, 1'b0, 8'd0, 1'b0);
        expect_out("t1.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t1.b2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t1.b3", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("t1.done", 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back (0,2,0),(1,4,1) with no gap
        token(1'b1, 1'b0, 8'd2, 1'b0);
        tick();
        token(1'b1, 1'b1, 8'd4, 1'b1);
        expect_out("t2.b1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("t2.b2", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        token(1'b0, 1'b0, 8'd0, 1'b0);
        expect_out("t2.b3", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t2.b4", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t2.b5", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t2.b6", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        expect_out("t2.done", 1'b0, 1'b0, 1'b0, 1'b1);

        // (1,5,0) with consumer stalls; in_ready only on the final-beat cycle
        token(1'b1, 1'b1, 8'd5, 1'b0);
        tick();
        token(1'b0, 1'b0, 8'd0, 1'b0);
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            out_ready = rdy[i][0];
            expect_out($sformatf("t3.c%0d", i), 1'b1, 1'b1, 1'b0, (i == 7));
            if (out_valid && out_ready) beats++;
            tick();
        end
        out_ready = 1'b1;
        check("t3.beats", beats, 5);
        expect_out("t3.done", 1'b0, 1'b0, 1'b0, 1'b1);

        // Zero-length token in IDLE
        token(1'b1, 1'b1, 8'd0, 1'b1);
        tick();
        token(1'b0, 1'b0, 8'd0, 1'b0);
        expect_out("t4.after", 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4.err_pulse", err_zero_len, 1'b1);
        tick();
        check("t4.err_clear", err_zero_len, 1'b0);

        // Zero-length token arriving on a run's final beat
        token(1'b1, 1'b1, 8'd1, 1'b0);
        tick();
        token(1'b1, 1'b0, 8'd0, 1'b1);
        expect_out("t5.b1", 1'b1, 1'b1, 1'b0, 1'b1);
        check("t5.err_before", err_zero_len, 1'b0);
        tick();
        token(1'b0, 1'b0, 8'd0, 1'b0);
        expect_out("t5.after", 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5.err_pulse", err_zero_len, 1'b1);
        tick();

        // Maximum run (0,255,1)
        token(1'b1, 1'b0, 8'd255, 1'b1);
        tick();
        token(1'b0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 255; i++) begin
            expect_out($sformatf("t6.b%0d", i + 1), 1'b1, 1'b0, (i == 254), (i == 254));
            tick();
        end
        expect_out("t6.done", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-run of (1,6,0), then a single-bit token
        token(1'b1, 1'b1, 8'd6, 1'b0);
        tick();
        token(1'b0, 1'b0, 8'd0, 1'b0);
        expect_out("t7.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t7.b2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        expect_out("t7.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t7.rst_bit", out_bit, 1'b0);
        tick();
        reset = 1'b1;
        expect_out("t7.rel", 1'b0, 1'b0, 1'b0, 1'b1);
        token(1'b1, 1'b0, 8'd1, 1'b0);
        tick();
        token(1'b0, 1'b0, 8'd0, 1'b0);
        expect_out("t7.new", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("t7.done", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
